// File: rtl/switch_top_transpose.sv
// switch_top_transpose: pipelined N x N matrix transpose / pass-through over a log2(N)-stage block-swap network
// Ports: clk, rst (sync, active-high), ctrl (1 = transpose, 0 = pass-through, travels with its matrix),
//        input_matrix[row][col] in, output_matrix[row][col] out.
// Build option: SWITCH_TOP_OUT_REG_EN adds an output register (latency L+2, else L+1; L = log2(ROWS)).
module switch_top_transpose #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl,
    input  logic [DATA_W-1:0] input_matrix  [0:ROWS-1][0:COLS-1],
    output logic [DATA_W-1:0] output_matrix [0:ROWS-1][0:COLS-1]
);
    localparam int L = $clog2(ROWS);

    if (COLS != ROWS) begin : g_chk_cols
        $error("switch_top_transpose: COLS must equal ROWS");
    end
    if (ROWS < 2 || (1 << L) != ROWS) begin : g_chk_rows
        $error("switch_top_transpose: ROWS must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] input_elements  [0:ROWS-1][0:COLS-1];
    logic [DATA_W-1:0] output_elements [0:ROWS-1][0:COLS-1];
    logic [DATA_W-1:0] prev    [1:L][0:ROWS-1][0:COLS-1];
    logic [DATA_W-1:0] stage_d [1:L][0:ROWS-1][0:COLS-1];
    logic [DATA_W-1:0] stage_q [1:L][0:ROWS-1][0:COLS-1];
    logic [L-1:0]      ctrl_d, ctrl_q;

    // ctrl_q[k-1] is the mode of the matrix currently entering stage k
    always_comb begin
        ctrl_d    = ctrl_q << 1;
        ctrl_d[0] = ctrl;
    end

    // Stage k swaps elements whose row and column differ in the bit of weight B,
    // moving (i,j) to (i^B, j^B); all other elements hold position.
    for (genvar k = 1; k <= L; k++) begin : g_stg
        localparam int B = 1 << (L - k);
        for (genvar i = 0; i < ROWS; i++) begin : g_row
            for (genvar j = 0; j < COLS; j++) begin : g_col
                localparam bit SW = ((i ^ j) & B) != 0;
                if (k == 1) begin : g_first
                    assign prev[k][i][j] = input_elements[i][j];
                end else begin : g_next
                    assign prev[k][i][j] = stage_q[k-1][i][j];
                end
                assign stage_d[k][i][j] = (SW && ctrl_q[k-1]) ? prev[k][i ^ B][j ^ B] : prev[k][i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        ctrl_q <= rst ? '0 : ctrl_d;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                input_elements[i][j] <= rst ? '0 : input_matrix[i][j];
                for (int k = 1; k <= L; k++) begin
                    stage_q[k][i][j] <= rst ? '0 : stage_d[k][i][j];
                end
            end
        end
    end

`ifdef SWITCH_TOP_OUT_REG_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                output_elements[i][j] <= rst ? '0 : stage_q[L][i][j];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                output_elements[i][j] = stage_q[L][i][j];
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                output_matrix[i][j] = output_elements[i][j];
            end
        end
    end
endmodule

// File: tb/tb_switch_top_transpose.sv
// tb_switch_top_transpose: randomized self-checking bench for switch_top_transpose
module tb_switch_top_transpose;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int L    = 2;
    localparam int MAXC = 1024;
`ifdef SWITCH_TOP_OUT_REG_EN
    localparam int LAT = L + 2;
`else
    localparam int LAT = L + 1;
`endif

    typedef logic [W-1:0] mat_t [0:N-1][0:N-1];

    logic clk = 1'b0;
    logic rst;
    logic ctrl;
    mat_t in_m;
    mat_t out_m;

    always #5 clk = ~clk;

    switch_top_transpose #(.DATA_W(W), .ROWS(N), .COLS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl          (ctrl),
        .input_matrix  (in_m),
        .output_matrix (out_m)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    mat_t h_in [MAXC];
    bit   h_c  [MAXC];
    bit   h_r  [MAXC];

    task automatic step(input bit r, input bit c, input mat_t m);
        rst  = r;
        ctrl = c;
        in_m = m;
        h_in[cyc] = m;
        h_c[cyc]  = c;
        h_r[cyc]  = r;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output after edge t is the matrix sampled LAT-1 edges earlier, transposed or copied
    // according to its own ctrl, or zero if reset was high anywhere in that window.
    task automatic model(output mat_t e);
        int t = cyc - 1;
        int s = t - LAT + 1;
        bit z = (s < 0);
        for (int k = (s < 0) ? 0 : s; k <= t; k++) if (h_r[k]) z = 1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                e[i][j] = z ? '0 : (h_c[s] ? h_in[s][j][i] : h_in[s][i][j]);
    endtask

    task automatic rnd(output mat_t m);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'($urandom);
    endtask

    task automatic test_reset;
        mat_t m, e;
        bit bad;
        rnd(m);
        step(1, 1, m);
        step(1, 0, m);
        model(e);
        tests++;
        if (out_m != e) begin
            fails++;
            $display("FAIL reset_out: got %p want %p", out_m, e);
        end
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (dut.input_elements[i][j] !== '0) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_capture: got %p want all zero", dut.input_elements);
        end
    endtask

    task automatic test_transpose;
        mat_t m, e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'(8'h10 * i + 8'h0A + j);
        step(1, 1, m);
        for (int n = 1; n <= LAT + 2; n++) begin
            step(0, 1, m);
            model(e);
            tests++;
            if (out_m != e) begin
                fails++;
                $display("FAIL transpose_edge%0d: got %p want %p", n, out_m, e);
            end
            if (n == 1) begin
                tests++;
                if (dut.input_elements[1][2] !== 8'h1C) begin
                    fails++;
                    $display("FAIL transpose_capture: got %h want 1c", dut.input_elements[1][2]);
                end
            end
            if (n == LAT - 1) begin
                tests++;
                if (out_m[0][1] !== 8'h00) begin
                    fails++;
                    $display("FAIL transpose_early: got %h want 00", out_m[0][1]);
                end
            end
            if (n == LAT) begin
                tests++;
                if (out_m[0][1] !== 8'h1A || out_m[3][0] !== 8'h0D || out_m[2][2] !== 8'h2C) begin
                    fails++;
                    $display("FAIL transpose_const: got %h %h %h want 1a 0d 2c",
                             out_m[0][1], out_m[3][0], out_m[2][2]);
                end
            end
        end
    endtask

    task automatic test_passthrough;
        mat_t m, e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'(8'h10 * i + 8'h0A + j);
        step(1, 0, m);
        for (int n = 1; n <= LAT + 1; n++) begin
            step(0, 0, m);
            model(e);
            tests++;
            if (out_m != e) begin
                fails++;
                $display("FAIL pass_edge%0d: got %p want %p", n, out_m, e);
            end
            if (n == LAT) begin
                tests++;
                if (out_m[0][1] !== 8'h0B || out_m[3][0] !== 8'h3A) begin
                    fails++;
                    $display("FAIL pass_const: got %h %h want 0b 3a", out_m[0][1], out_m[3][0]);
                end
            end
        end
    endtask

    task automatic test_stream;
        mat_t m, e;
        for (int n = 0; n < 60; n++) begin
            rnd(m);
            step(0, (n < 30) ? n[0] : 1'($urandom), m);
            model(e);
            tests++;
            if (out_m != e) begin
                fails++;
                $display("FAIL stream_%0d: got %p want %p", n, out_m, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        mat_t m, e;
        for (int n = 0; n < 22; n++) begin
            rnd(m);
            step(n == 8 || n == 9, 1'($urandom), m);
            model(e);
            tests++;
            if (out_m != e) begin
                fails++;
                $display("FAIL reset_mid_%0d: got %p want %p", n, out_m, e);
            end
            if (n == 9 + LAT - 1) begin
                tests++;
                if (out_m[1][2] !== 8'h00 || out_m[3][3] !== 8'h00) begin
                    fails++;
                    $display("FAIL reset_mid_hold: got %h %h want 00 00", out_m[1][2], out_m[3][3]);
                end
            end
        end
    endtask

    task automatic test_extremes;
        mat_t ff, d, e;
        bit bad;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ff[i][j] = 8'hFF;
                d[i][j]  = (i == j) ? W'(8'h11 * (i + 1)) : 8'h00;
            end
        for (int mode = 0; mode < 4; mode++) begin
            for (int n = 0; n < LAT; n++) begin
                step(0, mode[0], mode[1] ? d : ff);
                model(e);
                tests++;
                if (out_m != e) begin
                    fails++;
                    $display("FAIL extreme_m%0d_%0d: got %p want %p", mode, n, out_m, e);
                end
            end
            bad = 0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (out_m[i][j] !== (mode[1] ? d[i][j] : 8'hFF)) bad = 1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL extreme_const_m%0d: got %p", mode, out_m);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        ctrl = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                in_m[i][j] = '0;
        test_reset;
        test_transpose;
        test_passthrough;
        test_stream;
        test_reset_mid;
        test_extremes;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
